// File: rtl/store_write_buffer_pkg.sv
// Shared types and constants for the store write buffer.
package store_write_buffer_pkg;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10,
    SX = 2'b11
  } st_sel_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  localparam int ENTRY_W = 66;

endpackage

// File: rtl/store_write_buffer_st_lane_align.sv
// Places store data into its byte lanes, builds byte enables and flags illegal or misaligned stores.
module st_lane_align
  import store_write_buffer_pkg::*;
(
  input  logic [31:0] st_data,
  input  logic [1:0]  st_sel,
  input  logic [1:0]  off,
  output logic [31:0] data_sh,
  output logic [3:0]  be,
  output logic        legal
);

  always_comb begin
    data_sh = st_data << {off, 3'b000};
    be      = 4'b0000;
    legal   = 1'b0;
    case (st_sel)
      SB: begin
        be    = 4'b0001 << off;
        legal = 1'b1;
      end
      SH: begin
        be    = 4'b0011 << off;
        legal = ~off[0];
      end
      SW: begin
        be    = 4'b1111;
        legal = (off == 2'b00);
      end
      default: begin
        be    = 4'b0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// In-order store write buffer: queues aligned stores for data memory and flags loads that hit a buffered word.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_sel,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        st_err,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        data_sh;
  logic [3:0]         be;
  logic               legal;
  logic               push;
  logic               pop;
  logic               handshake;
  entry_t             head;
  logic [PTR_W-1:0]   idx;

  st_lane_align u_align (
    .st_data (st_data),
    .st_sel  (st_sel),
    .off     (st_addr[1:0]),
    .data_sh (data_sh),
    .be      (be),
    .legal   (legal)
  );

  assign st_ready  = (count < CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign mem_req   = ~empty;
  assign handshake = st_valid & st_ready;
  assign push      = handshake & legal;
  assign pop       = mem_req & mem_gnt;

  // Outputs read as zero whenever nothing is queued, which also covers reset.
  assign head      = entries[rd_ptr];
  assign mem_addr  = empty ? 32'h0 : {head.addr, 2'b00};
  assign mem_wdata = empty ? 32'h0 : head.data;
  assign mem_be    = empty ? 4'h0  : head.be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= handshake & ~legal;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= '{addr: st_addr[31:2], data: data_sh, be: be};
  end

  // An entry leaving this cycle is still counted as valid for the load check.
  always_comb begin
    ld_hit = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) &&
          ((ld_addr & 32'hFFFF_FFFC) == {entries[idx].addr, 2'b00}))
        ld_hit = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer with DEPTH=4.
module tb_store_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_sel;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        st_err;
  logic        empty;

  int passed = 0;
  int total  = 0;

  store_write_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_sel    (st_sel),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .st_err    (st_err),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sel   = s;
  endtask

  initial begin
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_sel   = 2'b00;
    mem_gnt  = 1'b0;
    ld_addr  = '0;
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_st_ready", 32'(st_ready), 32'h1);
    chk("rst_st_err", 32'(st_err), 32'h0);
    chk("rst_ld_hit", 32'(ld_hit), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Byte store at offset 3
    offer(32'h1003, 32'h0000_00AB, 2'b00);
    #1;
    chk("sb_ready", 32'(st_ready), 32'h1);
    step();
    st_valid = 1'b0;
    chk("sb_mem_req", 32'(mem_req), 32'h1);
    chk("sb_mem_addr", mem_addr, 32'h0000_1000);
    chk("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
    chk("sb_mem_be", 32'(mem_be), 32'h8);
    chk("sb_empty", 32'(empty), 32'h0);
    chk("sb_no_err", 32'(st_err), 32'h0);
    ld_addr = 32'h1001;
    #1;
    chk("sb_ld_hit", 32'(ld_hit), 32'h1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sb_popped_empty", 32'(empty), 32'h1);
    chk("sb_popped_req", 32'(mem_req), 32'h0);
    chk("sb_popped_hit", 32'(ld_hit), 32'h0);

    // Misaligned half store
    offer(32'h2001, 32'h0000_1234, 2'b01);
    step();
    st_valid = 1'b0;
    chk("msh_err", 32'(st_err), 32'h1);
    chk("msh_empty", 32'(empty), 32'h1);
    chk("msh_req", 32'(mem_req), 32'h0);
    step();
    chk("msh_err_clear", 32'(st_err), 32'h0);
    chk("msh_empty2", 32'(empty), 32'h1);

    // Illegal width encoding and misaligned word
    offer(32'h0000_0000, 32'h1, 2'b11);
    step();
    offer(32'h0000_0002, 32'h1, 2'b10);
    chk("sel11_err", 32'(st_err), 32'h1);
    step();
    st_valid = 1'b0;
    chk("msw_err", 32'(st_err), 32'h1);
    chk("msw_empty", 32'(empty), 32'h1);
    step();
    chk("msw_err_clear", 32'(st_err), 32'h0);

    // Half store at offset 2
    offer(32'h4002, 32'h0000_1234, 2'b01);
    step();
    st_valid = 1'b0;
    chk("sh2_err", 32'(st_err), 32'h0);
    chk("sh2_addr", mem_addr, 32'h0000_4000);
    chk("sh2_wdata", mem_wdata, 32'h1234_0000);
    chk("sh2_be", 32'(mem_be), 32'hC);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sh2_empty", 32'(empty), 32'h1);

    // Fill to four entries, fifth waits for the first grant
    for (int k = 0; k < 4; k++) begin
      offer(32'h100 + 32'(4 * k), 32'h1111_1111 * (k + 1), 2'b10);
      step();
    end
    offer(32'h110, 32'h5555_5555, 2'b10);
    #1;
    chk("fill_ready0", 32'(st_ready), 32'h0);
    chk("fill_head_addr", mem_addr, 32'h0000_0100);
    step();
    chk("stall_ready0", 32'(st_ready), 32'h0);
    chk("stall_addr", mem_addr, 32'h0000_0100);
    chk("stall_wdata", mem_wdata, 32'h1111_1111);
    chk("stall_be", 32'(mem_be), 32'hF);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("grant_ready1", 32'(st_ready), 32'h1);
    chk("grant_next_addr", mem_addr, 32'h0000_0104);
    step();
    st_valid = 1'b0;
    chk("fifth_in_ready0", 32'(st_ready), 32'h0);
    mem_gnt = 1'b1;
    chk("drain0_addr", mem_addr, 32'h0000_0104);
    chk("drain0_data", mem_wdata, 32'h2222_2222);
    step();
    chk("drain1_addr", mem_addr, 32'h0000_0108);
    chk("drain1_data", mem_wdata, 32'h3333_3333);
    step();
    chk("drain2_addr", mem_addr, 32'h0000_010C);
    chk("drain2_data", mem_wdata, 32'h4444_4444);
    step();
    chk("drain3_addr", mem_addr, 32'h0000_0110);
    chk("drain3_data", mem_wdata, 32'h5555_5555);
    step();
    mem_gnt = 1'b0;
    chk("drain_empty", 32'(empty), 32'h1);

    // Push and pop in the same cycle at count 2
    offer(32'h200, 32'hA0A0_A0A0, 2'b10);
    step();
    offer(32'h204, 32'hB0B0_B0B0, 2'b10);
    step();
    offer(32'h208, 32'hC0C0_C0C0, 2'b10);
    mem_gnt = 1'b1;
    step();
    st_valid = 1'b0;
    chk("pp_ready", 32'(st_ready), 32'h1);
    chk("pp_next_addr", mem_addr, 32'h0000_0204);
    chk("pp_next_data", mem_wdata, 32'hB0B0_B0B0);
    step();
    chk("pp_last_addr", mem_addr, 32'h0000_0208);
    chk("pp_last_data", mem_wdata, 32'hC0C0_C0C0);
    step();
    mem_gnt = 1'b0;
    chk("pp_empty", 32'(empty), 32'h1);

    // Load forwarding check
    offer(32'h3002, 32'h0000_5678, 2'b01);
    step();
    st_valid = 1'b0;
    ld_addr = 32'h3000;
    #1;
    chk("fwd_hit", 32'(ld_hit), 32'h1);
    ld_addr = 32'h3004;
    #1;
    chk("fwd_miss", 32'(ld_hit), 32'h0);
    chk("fwd_wdata", mem_wdata, 32'h5678_0000);
    chk("fwd_be", 32'(mem_be), 32'hC);
    ld_addr = 32'h3000;
    mem_gnt = 1'b1;
    #1;
    chk("fwd_hit_popping", 32'(ld_hit), 32'h1);
    step();
    mem_gnt = 1'b0;
    chk("fwd_after_grant", 32'(ld_hit), 32'h0);

    // Reset with three entries queued and a grant pending
    for (int k = 0; k < 3; k++) begin
      offer(32'h400 + 32'(4 * k), 32'hD000_0000 + 32'(k), 2'b10);
      step();
    end
    st_valid = 1'b0;
    ld_addr = 32'h404;
    #1;
    chk("pre_rst_req", 32'(mem_req), 32'h1);
    chk("pre_rst_hit", 32'(ld_hit), 32'h1);
    mem_gnt = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'h0);
    chk("mid_rst_empty", 32'(empty), 32'h1);
    chk("mid_rst_ready", 32'(st_ready), 32'h1);
    chk("mid_rst_hit", 32'(ld_hit), 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_req", 32'(mem_req), 32'h0);
    chk("post_rst_empty", 32'(empty), 32'h1);
    step();
    chk("post_rst_req2", 32'(mem_req), 32'h0);
    chk("post_rst_wdata", mem_wdata, 32'h0);
    mem_gnt = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the buffer entry count; power of two, at least 2.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port st_valid  input  1  a store request is offered.
REQ-005 The block SHALL have port st_ready  output  1  the buffer can accept a request this cycle.
REQ-006 The block SHALL have port st_addr  input  32  store byte address.
REQ-007 The block SHALL have port st_data  input  32  store data, zero-extended, value in the low lanes.
REQ-008 The block SHALL have port st_sel  input  2  store width: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 The block SHALL have port mem_req  output  1  a write to data memory is pending.
REQ-010 The block SHALL have port mem_gnt  input  1  memory accepts the pending write this cycle.
REQ-011 The block SHALL have port mem_addr  output  32  word-aligned write address, bits [1:0] always 0.
REQ-012 The block SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-013 The block SHALL have port mem_be  output  4  byte enables; bit i enables mem_wdata[8i+7:8i].
REQ-014 The block SHALL have port ld_addr  input  32  address of a load being issued.
REQ-015 The block SHALL have port ld_hit  output  1  a buffered store targets the same word as ld_addr.
REQ-016 The block SHALL have port st_err  output  1  one-cycle pulse for a misaligned or illegal store.
REQ-017 The block SHALL have port empty  output  1  no entries are buffered.

Function
REQ-018 A store handshake SHALL complete on a rising edge with st_valid=1 and st_ready=1.
REQ-019 st_ready SHALL equal 1 exactly when the entry count is below DEPTH; it SHALL NOT depend on mem_gnt.
REQ-020 Offset off=st_addr[1:0]. A store SHALL be legal when: sel=00 at any off; sel=01 with off[0]=0; sel=10 with off=00.
REQ-021 A legal store SHALL enqueue {st_addr[31:2],2'b00}, data st_data shifted left by 8*off, and its enables.
REQ-022 Enables SHALL be: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
REQ-023 An illegal or misaligned store SHALL complete its handshake, SHALL NOT be enqueued, and SHALL raise st_err for exactly the following cycle.
REQ-024 mem_req SHALL equal the inverse of empty; mem_addr, mem_wdata and mem_be SHALL present the oldest entry, and SHALL be stable while mem_req=1 and mem_gnt=0.
REQ-025 An entry SHALL be popped on a rising edge with mem_req=1 and mem_gnt=1; mem_gnt while mem_req=0 SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order; with count=DEPTH, the pop proceeds and the push waits because st_ready=0.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-028 Entries SHALL NOT be merged or coalesced; each legal store produces exactly one memory write.
REQ-029 ld_hit SHALL be combinational: 1 iff some valid entry's address equals {ld_addr[31:2],2'b00}; an entry being popped this cycle still counts.
REQ-030 Write latency: a legal store into an empty buffer SHALL assert mem_req in the cycle after its handshake.

Reset
REQ-031 On rst_n=0 the block SHALL immediately set count=0, clear both pointers, and drive mem_req=0, empty=1, st_ready=1, st_err=0 and ld_hit=0.
REQ-032 On rst_n=0, mem_addr, mem_wdata and mem_be SHALL go to 0, and entry storage need not be cleared.
REQ-033 Assertion of reset mid-operation SHALL discard all buffered stores, including one whose mem_gnt arrives in the same cycle.

Structure
REQ-034 Shared package contents SHALL be: the st_sel encodings (SB=00, SH=01, SW=10), the entry record type {addr[31:2], data[31:0], be[3:0]}, and the constant ENTRY_W=66.
REQ-035 A combinational sub-module st_lane_align SHALL compute shifted data, enables and the legality flag from st_data, st_sel and the offset.

Verification
REQ-036 Check this sb scenario: with addr=0x1003, data=0x000000AB, sel=00, the next cycle SHALL show mem_req=1, mem_addr=0x1000, mem_wdata=0xAB000000, mem_be=1000.
REQ-037 Check this misaligned sh scenario: with addr=0x2001, sel=01, the following cycle SHALL show st_err=1 for one cycle, with empty staying 1 and mem_req staying 0.
REQ-038 Check fill and stall: push 5 sw stores with mem_gnt=0; after 4, st_ready=0, and the 5th SHALL be accepted only in the cycle after the first mem_gnt, with order preserved.
REQ-039 Check simultaneous push and pop: at count=2, push and grant in the same cycle SHALL leave count=2, and the next write presented SHALL be the second-oldest store.
REQ-040 Check forwarding: with sh 0x3002 buffered, ld_addr=0x3000 SHALL give ld_hit=1 and ld_addr=0x3004 SHALL give ld_hit=0; after the grant, ld_addr=0x3000 SHALL give ld_hit=0.
REQ-041 Check reset with 3 entries buffered and mem_gnt=1: asserting rst_n=0 SHALL make mem_req=0 and empty=1 at once, and no write SHALL appear after release.
